pipe_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the five-stage RV32I pipeline. It computes EX-stage operand forwarding selects and detects load-use hazards. It also sequences taken-branch flushes and freezes every pipeline register while a data-memory access is outstanding. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and drives their stall/flush controls.

---
 rtl/riscv_pipe_pkg.sv | 18 +
 rtl/pipe_hazard_ctrl_fwd_unit.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared types and control-word bit positions for the five-stage RV32I pipeline.
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b01
  } fwd_sel_e;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } memctl_state_e;

  localparam int CRT_WB_REGWRITE = 0;
  localparam int CRT_WB_MEM2REG  = 1;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX-stage forwarding select for a single source operand; the younger EX/MEM
// producer wins over MEM/WB, and x0 is never forwarded.
module fwd_unit
  import riscv_pipe_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] exmem_rd,
  input  logic       exmem_reg_write,
  input  logic [4:0] memwb_rd,
  input  logic       memwb_reg_write,
  output fwd_sel_e   sel
);

  always_comb begin
    sel = FWD_RF;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller: forwarding, load-use stall, branch flush,
// and a memory-wait freeze with timeout.
module pipe_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  idex_rs1,
  input  logic [4:0]  idex_rs2,
  input  logic [4:0]  idex_rd,
  input  logic        idex_mem_read,
  input  logic [4:0]  exmem_rd,
  input  logic [1:0]  exmem_crt_wb,
  input  logic        exmem_mem_req,
  input  logic [4:0]  memwb_rd,
  input  logic [1:0]  memwb_crt_wb,
  input  logic        branch_taken,
  input  logic        dmem_ready,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        freeze,
  output logic        mem_err,
  output logic [31:0] stall_cnt
);

  memctl_state_e state_q, state_d;
  logic [15:0]   tmo_cnt_q, tmo_cnt_d;
  logic          mem_err_q;
  logic [31:0]   stall_cnt_q;
  logic          wait_freeze;
  logic          err_set;
  logic          tmo_hit;
  logic          load_use;
  fwd_sel_e      sel_a, sel_b;
  logic          unused_mem2reg;

  assign unused_mem2reg = exmem_crt_wb[CRT_WB_MEM2REG] ^ memwb_crt_wb[CRT_WB_MEM2REG];

  fwd_unit u_fwd_a (
    .rs              (idex_rs1),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_crt_wb[CRT_WB_REGWRITE]),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_crt_wb[CRT_WB_REGWRITE]),
    .sel             (sel_a)
  );

  fwd_unit u_fwd_b (
    .rs              (idex_rs2),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_crt_wb[CRT_WB_REGWRITE]),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_crt_wb[CRT_WB_REGWRITE]),
    .sel             (sel_b)
  );

  // The wait cycle in which the counter would reach MEM_TIMEOUT is the abort cycle.
  assign tmo_hit = ({1'b0, tmo_cnt_q} + 17'd1) >= 17'(MEM_TIMEOUT);

  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    wait_freeze = 1'b0;
    err_set     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (exmem_mem_req && !dmem_ready) begin
          wait_freeze = 1'b1;
          state_d     = ST_MEM_WAIT;
          tmo_cnt_d   = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = ST_RUN;
        end else if (tmo_hit) begin
          err_set = 1'b1;
          state_d = ST_RUN;
        end else begin
          wait_freeze = 1'b1;
          tmo_cnt_d   = tmo_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign load_use = idex_mem_read && (idex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == idex_rd)) ||
                     (id_use_rs2 && (id_rs2 == idex_rd)));

  always_comb begin
    freeze      = 1'b0;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    if (!rst) begin
      if (wait_freeze) begin
        freeze     = 1'b1;
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
      end else if (branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_bubble = 1'b1;
      end
    end
  end

  assign fwd_a     = rst ? 2'b00 : sel_a;
  assign fwd_b     = rst ? 2'b00 : sel_b;
  assign mem_err   = mem_err_q && !rst;
  assign stall_cnt = rst ? 32'd0 : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      tmo_cnt_q   <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      if (err_set) begin
        mem_err_q <= 1'b1;
      end
      if (pc_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, hand-written memory-wait
// sequences and randomized traffic against a behavioural reference model.
module tb_pipe_hazard_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_use_rs1, id_use_rs2;
  logic [4:0]  idex_rs1, idex_rs2, idex_rd;
  logic        idex_mem_read;
  logic [4:0]  exmem_rd;
  logic [1:0]  exmem_crt_wb;
  logic        exmem_mem_req;
  logic [4:0]  memwb_rd;
  logic [1:0]  memwb_crt_wb;
  logic        branch_taken;
  logic        dmem_ready;
  logic [1:0]  fwd_a, fwd_b;
  logic        pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush;
  logic        freeze, mem_err;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: an access may consume at most TMO freeze cycles.
  logic        m_busy;
  int          m_frz_used;
  logic        m_err;
  logic [31:0] m_stalls;
  logic [1:0]  e_fwd_a, e_fwd_b;
  logic        e_freeze, e_stall, e_bubble, e_flush, e_err;
  logic [31:0] e_cnt;

  typedef struct {
    logic [4:0] idex_rs1;
    logic [4:0] idex_rs2;
    logic [4:0] exmem_rd;
    logic [1:0] exmem_wb;
    logic [4:0] memwb_rd;
    logic [1:0] memwb_wb;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       use1;
    logic       use2;
    logic [4:0] idex_rd;
    logic       ld;
    logic       br;
    logic [1:0] x_fa;
    logic [1:0] x_fb;
    logic       x_stall;
    logic       x_flush;
  } vec_t;

  vec_t vecs[11];

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .idex_rs1      (idex_rs1),
    .idex_rs2      (idex_rs2),
    .idex_rd       (idex_rd),
    .idex_mem_read (idex_mem_read),
    .exmem_rd      (exmem_rd),
    .exmem_crt_wb  (exmem_crt_wb),
    .exmem_mem_req (exmem_mem_req),
    .memwb_rd      (memwb_rd),
    .memwb_crt_wb  (memwb_crt_wb),
    .branch_taken  (branch_taken),
    .dmem_ready    (dmem_ready),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .pc_stall      (pc_stall),
    .ifid_stall    (ifid_stall),
    .idex_bubble   (idex_bubble),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .freeze        (freeze),
    .mem_err       (mem_err),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] src);
    if (src != 5'd0 && exmem_crt_wb[0] && exmem_rd == src) return 2'b10;
    if (src != 5'd0 && memwb_crt_wb[0] && memwb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic compute_expected();
    logic active, lu;
    e_fwd_a = 2'b00; e_fwd_b = 2'b00; e_freeze = 1'b0; e_stall = 1'b0;
    e_bubble = 1'b0; e_flush = 1'b0; e_err = 1'b0; e_cnt = 32'd0;
    if (!rst) begin
      e_fwd_a  = fwd_ref(idex_rs1);
      e_fwd_b  = fwd_ref(idex_rs2);
      active   = m_busy || exmem_mem_req;
      e_freeze = active && !dmem_ready && (m_frz_used < TMO);
      lu = idex_mem_read && idex_rd != 5'd0 &&
           ((id_use_rs1 && id_rs1 == idex_rd) || (id_use_rs2 && id_rs2 == idex_rd));
      e_flush  = !e_freeze && branch_taken;
      e_bubble = !e_freeze && !branch_taken && lu;
      e_stall  = e_freeze || e_bubble;
      e_err    = m_err;
      e_cnt    = m_stalls;
    end
  endtask

  task automatic update_model();
    if (rst) begin
      m_busy = 1'b0; m_frz_used = 0; m_err = 1'b0; m_stalls = 32'd0;
    end else begin
      if (e_stall && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 32'd1;
      if (m_busy || exmem_mem_req) begin
        if (dmem_ready) begin
          m_busy = 1'b0; m_frz_used = 0;
        end else if (e_freeze) begin
          m_busy = 1'b1; m_frz_used++;
        end else begin
          m_err = 1'b1; m_busy = 1'b0; m_frz_used = 0;
        end
      end
    end
  endtask

  task automatic check_output();
    check_val("fwd_a", {30'd0, fwd_a}, {30'd0, e_fwd_a});
    check_val("fwd_b", {30'd0, fwd_b}, {30'd0, e_fwd_b});
    check_val("pc_stall", {31'd0, pc_stall}, {31'd0, e_stall});
    check_val("ifid_stall", {31'd0, ifid_stall}, {31'd0, e_stall});
    check_val("idex_bubble", {31'd0, idex_bubble}, {31'd0, e_bubble});
    check_val("ifid_flush", {31'd0, ifid_flush}, {31'd0, e_flush});
    check_val("idex_flush", {31'd0, idex_flush}, {31'd0, e_flush});
    check_val("freeze", {31'd0, freeze}, {31'd0, e_freeze});
    check_val("mem_err", {31'd0, mem_err}, {31'd0, e_err});
    check_val("stall_cnt", stall_cnt, e_cnt);
  endtask

  task automatic eval_cycle();
    #1;
    compute_expected();
    check_output();
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input vec_t v);
    idex_rs1 = v.idex_rs1; idex_rs2 = v.idex_rs2;
    exmem_rd = v.exmem_rd; exmem_crt_wb = v.exmem_wb;
    memwb_rd = v.memwb_rd; memwb_crt_wb = v.memwb_wb;
    id_rs1 = v.id_rs1; id_rs2 = v.id_rs2;
    id_use_rs1 = v.use1; id_use_rs2 = v.use2;
    idex_rd = v.idex_rd; idex_mem_read = v.ld; branch_taken = v.br;
    exmem_mem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic set_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    idex_rs1 = 5'd0; idex_rs2 = 5'd0; idex_rd = 5'd0; idex_mem_read = 1'b0;
    exmem_rd = 5'd0; exmem_crt_wb = 2'b00; exmem_mem_req = 1'b0;
    memwb_rd = 5'd0; memwb_crt_wb = 2'b00; branch_taken = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic set_load_use();
    idex_mem_read = 1'b1; idex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // idex_rs1 rs2 exm_rd exm_wb mwb_rd mwb_wb id_rs1 id_rs2 u1 u2 idex_rd ld br | fa fb stall flush
    vecs[0]  = '{5'd5, 5'd0, 5'd5, 2'b01, 5'd5, 2'b01, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0};
    vecs[1]  = '{5'd5, 5'd9, 5'd5, 2'b00, 5'd5, 2'b01, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0};
    vecs[2]  = '{5'd0, 5'd0, 5'd0, 2'b01, 5'd0, 2'b01, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[3]  = '{5'd3, 5'd3, 5'd3, 2'b10, 5'd3, 2'b11, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0};
    vecs[4]  = '{5'd7, 5'd6, 5'd6, 2'b11, 5'd7, 2'b01, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 1'b0};
    vecs[5]  = '{5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 2'b00, 5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    vecs[6]  = '{5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 2'b00, 5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[7]  = '{5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 2'b00, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[8]  = '{5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 2'b00, 5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1};
    vecs[9]  = '{5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1};
    vecs[10] = '{5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 2'b00, 5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};

    m_busy = 1'b0; m_frz_used = 0; m_err = 1'b0; m_stalls = 32'd0;
    set_idle();
    set_load_use();
    branch_taken = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    eval_cycle();
    check_val("reset_pc_stall", {31'd0, pc_stall}, 32'd0);
    check_val("reset_flush", {31'd0, ifid_flush}, 32'd0);
    finish_cycle();
    eval_cycle();
    finish_cycle();
    rst = 1'b0;
    set_idle();

    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i]);
      eval_cycle();
      check_val($sformatf("vec%0d_fwd_a", i), {30'd0, fwd_a}, {30'd0, vecs[i].x_fa});
      check_val($sformatf("vec%0d_fwd_b", i), {30'd0, fwd_b}, {30'd0, vecs[i].x_fb});
      check_val($sformatf("vec%0d_stall", i), {31'd0, pc_stall}, {31'd0, vecs[i].x_stall});
      check_val($sformatf("vec%0d_bubble", i), {31'd0, idex_bubble}, {31'd0, vecs[i].x_stall});
      check_val($sformatf("vec%0d_flush", i), {31'd0, idex_flush}, {31'd0, vecs[i].x_flush});
      finish_cycle();
    end
    set_idle();
    eval_cycle();
    check_val("loaduse_stall_cnt", stall_cnt, 32'd1);
    finish_cycle();

    // Three-cycle memory wait with a taken branch parked in EX.
    exmem_mem_req = 1'b1;
    branch_taken  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      eval_cycle();
      check_val("wait_freeze", {31'd0, freeze}, 32'd1);
      check_val("wait_no_flush", {31'd0, ifid_flush}, 32'd0);
      finish_cycle();
    end
    dmem_ready = 1'b1;
    eval_cycle();
    check_val("ready_freeze", {31'd0, freeze}, 32'd0);
    check_val("ready_flush", {31'd0, idex_flush}, 32'd1);
    finish_cycle();
    set_idle();
    eval_cycle();
    check_val("back_to_run", {31'd0, freeze}, 32'd0);
    check_val("wait_stall_cnt", stall_cnt, 32'd4);
    finish_cycle();

    // Ready never arrives: TMO freeze cycles, then the abort cycle.
    exmem_mem_req = 1'b1;
    for (int i = 0; i < TMO; i++) begin
      eval_cycle();
      check_val("tmo_freeze", {31'd0, freeze}, 32'd1);
      finish_cycle();
    end
    exmem_mem_req = 1'b0;
    eval_cycle();
    check_val("tmo_abort_freeze", {31'd0, freeze}, 32'd0);
    check_val("tmo_abort_err", {31'd0, mem_err}, 32'd0);
    finish_cycle();
    for (int i = 0; i < 3; i++) begin
      eval_cycle();
      check_val("tmo_err_sticky", {31'd0, mem_err}, 32'd1);
      check_val("tmo_run_freeze", {31'd0, freeze}, 32'd0);
      finish_cycle();
    end
    rst = 1'b1;
    eval_cycle();
    finish_cycle();
    rst = 1'b0;
    eval_cycle();
    check_val("err_cleared", {31'd0, mem_err}, 32'd0);
    finish_cycle();

    // Reset in the middle of a memory wait.
    exmem_mem_req = 1'b1;
    eval_cycle(); finish_cycle();
    eval_cycle(); finish_cycle();
    rst = 1'b1;
    set_load_use();
    branch_taken = 1'b1;
    idex_rs1 = 5'd5; exmem_rd = 5'd5; exmem_crt_wb = 2'b01;
    eval_cycle();
    check_val("midrst_freeze", {31'd0, freeze}, 32'd0);
    check_val("midrst_fwd_a", {30'd0, fwd_a}, 32'd0);
    check_val("midrst_stall_cnt", stall_cnt, 32'd0);
    finish_cycle();
    rst = 1'b0;
    set_idle();
    eval_cycle();
    check_val("midrst_run", {31'd0, freeze}, 32'd0);
    check_val("midrst_cnt_zero", stall_cnt, 32'd0);
    check_val("midrst_no_err", {31'd0, mem_err}, 32'd0);
    finish_cycle();

    // Saturation of the stall counter.
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    m_stalls = 32'hFFFF_FFFE;
    set_load_use();
    eval_cycle();
    check_val("sat_start", stall_cnt, 32'hFFFF_FFFE);
    finish_cycle();
    eval_cycle();
    check_val("sat_max", stall_cnt, 32'hFFFF_FFFF);
    finish_cycle();
    eval_cycle();
    check_val("sat_hold", stall_cnt, 32'hFFFF_FFFF);
    finish_cycle();
    rst = 1'b1;
    set_idle();
    eval_cycle(); finish_cycle();
    rst = 1'b0;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      rst           = ($urandom_range(0, 60) == 0);
      id_rs1        = 5'($urandom_range(0, 3));
      id_rs2        = 5'($urandom_range(0, 3));
      id_use_rs1    = 1'($urandom_range(0, 1));
      id_use_rs2    = 1'($urandom_range(0, 1));
      idex_rs1      = 5'($urandom_range(0, 3));
      idex_rs2      = 5'($urandom_range(0, 3));
      idex_rd       = 5'($urandom_range(0, 3));
      idex_mem_read = 1'($urandom_range(0, 1));
      exmem_rd      = 5'($urandom_range(0, 3));
      exmem_crt_wb  = 2'($urandom_range(0, 3));
      exmem_mem_req = ($urandom_range(0, 3) == 0);
      memwb_rd      = 5'($urandom_range(0, 3));
      memwb_crt_wb  = 2'($urandom_range(0, 3));
      branch_taken  = ($urandom_range(0, 3) == 0);
      dmem_ready    = ($urandom_range(0, 4) == 0);
      eval_cycle();
      finish_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
